cnn_conv_seq: RTL and testbench



---
 rtl/cnn_conv_seq.sv | 145 ++++++++++++++
 tb/tb_cnn_conv_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_seq.sv
// cnn_conv_seq: vsync/hsync/data sequencer walking pixels or KxK multi-channel windows
module cnn_conv_seq #(
  parameter int W_SIZE  = 12,
  parameter int W_DELAY = 12,
  parameter int K_MAX   = 5,
  parameter int W_CH    = 4,
  parameter int W_CNT   = 2*W_SIZE+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_mode,
  input  logic [2:0]         q_ksize,
  input  logic [1:0]         q_stride,
  input  logic [W_CH:0]      q_channels,
  input  logic [W_SIZE-1:0]  q_width,
  input  logic [W_SIZE-1:0]  q_height,
  input  logic [W_DELAY-1:0] q_start_up_delay,
  input  logic [W_DELAY-1:0] q_hsync_delay,
  input  logic               q_start,
  input  logic               q_abort,
  output logic               o_ctrl_vsync_run,
  output logic               o_ctrl_hsync_run,
  output logic               o_ctrl_data_run,
  output logic [W_DELAY-1:0] o_ctrl_vsync_cnt,
  output logic [W_DELAY-1:0] o_ctrl_hsync_cnt,
  output logic [W_SIZE-1:0]  o_row,
  output logic [W_SIZE-1:0]  o_col,
  output logic [2:0]         o_kx,
  output logic [2:0]         o_ky,
  output logic [W_CH-1:0]    o_ch,
  output logic               o_win_first,
  output logic               o_win_last,
  output logic [W_CNT-1:0]   o_data_count,
  output logic               o_end_frame,
  output logic               o_done,
  output logic               o_err
);
  typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, DATA, DONE} state_t;
  localparam logic [2:0]    KM = 3'(K_MAX);
  localparam logic [W_CH:0] CM = (W_CH+1)'(2**W_CH);
  state_t st;
  logic [2:0]         k_s;
  logic [1:0]         s_s;
  logic [W_CH:0]      c_s;
  logic [W_SIZE-1:0]  w_s, h_s;
  logic [W_DELAY-1:0] sd_s, hd_s;
  logic               bad, kx_last, ky_last, ch_last, tap_last, line_end, row_end;
  logic [W_SIZE+1:0]  col_nx, row_nx;
  always_comb begin
    bad = q_ksize == 3'd0 || q_ksize > KM || W_SIZE'(q_ksize) > q_width || W_SIZE'(q_ksize) > q_height ||
          q_stride == 2'd0 || q_channels == '0 || q_channels > CM || q_width == '0 || q_height == '0;
    kx_last = o_kx == k_s - 3'd1;
    ky_last = o_ky == k_s - 3'd1;
    ch_last = (W_CH+1)'(o_ch) == c_s - (W_CH+1)'(1);
    tap_last = kx_last && ky_last && ch_last;
    col_nx = (W_SIZE+2)'(o_col) + (W_SIZE+2)'(s_s) + (W_SIZE+2)'(k_s);
    row_nx = (W_SIZE+2)'(o_row) + (W_SIZE+2)'(s_s) + (W_SIZE+2)'(k_s);
    line_end = col_nx > (W_SIZE+2)'(w_s);
    row_end = row_nx > (W_SIZE+2)'(h_s);
    o_ctrl_vsync_run = st == VSYNC;
    o_ctrl_hsync_run = st == HSYNC;
    o_ctrl_data_run = st == DATA;
    o_done = st == DONE;
    o_win_first = st == DATA && o_kx == 3'd0 && o_ky == 3'd0 && o_ch == '0;
    o_win_last = st == DATA && tap_last;
    o_end_frame = st == DATA && tap_last && line_end && row_end;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      k_s <= '0;
      s_s <= '0;
      c_s <= '0;
      w_s <= '0;
      h_s <= '0;
      sd_s <= '0;
      hd_s <= '0;
      o_ctrl_vsync_cnt <= '0;
      o_ctrl_hsync_cnt <= '0;
      o_row <= '0;
      o_col <= '0;
      o_kx <= '0;
      o_ky <= '0;
      o_ch <= '0;
      o_data_count <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (st != IDLE && q_abort) begin
        st <= IDLE;
        o_ctrl_vsync_cnt <= '0;
        o_ctrl_hsync_cnt <= '0;
        o_row <= '0;
        o_col <= '0;
        o_kx <= '0;
        o_ky <= '0;
        o_ch <= '0;
      end else begin
        case (st)
          IDLE: if (q_start) begin
            if (bad) o_err <= 1'b1;
            else begin
              k_s <= q_mode ? q_ksize : 3'd1;
              s_s <= q_mode ? q_stride : 2'd1;
              c_s <= q_mode ? q_channels : (W_CH+1)'(1);
              w_s <= q_width;
              h_s <= q_height;
              sd_s <= q_start_up_delay;
              hd_s <= q_hsync_delay;
              o_data_count <= '0;
              st <= VSYNC;
            end
          end
          VSYNC: begin
            o_ctrl_vsync_cnt <= o_ctrl_vsync_cnt == sd_s ? '0 : o_ctrl_vsync_cnt + W_DELAY'(1);
            if (o_ctrl_vsync_cnt == sd_s) st <= HSYNC;
          end
          HSYNC: begin
            o_ctrl_hsync_cnt <= o_ctrl_hsync_cnt == hd_s ? '0 : o_ctrl_hsync_cnt + W_DELAY'(1);
            if (o_ctrl_hsync_cnt == hd_s) st <= DATA;
          end
          DATA: begin
            o_kx <= kx_last ? 3'd0 : o_kx + 3'd1;
            o_ky <= kx_last ? (ky_last ? 3'd0 : o_ky + 3'd1) : o_ky;
            o_ch <= kx_last && ky_last ? (ch_last ? '0 : o_ch + W_CH'(1)) : o_ch;
            if (tap_last) begin
              o_data_count <= o_data_count + W_CNT'(1);
              o_col <= line_end ? '0 : o_col + W_SIZE'(s_s);
              o_row <= !line_end ? o_row : row_end ? '0 : o_row + W_SIZE'(s_s);
              if (line_end) st <= row_end ? DONE : HSYNC;
            end
          end
          default: begin
            o_row <= '0;
            o_col <= '0;
            o_kx <= '0;
            o_ky <= '0;
            o_ch <= '0;
            st <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cnn_conv_seq.sv
// tb_cnn_conv_seq: directed frame runs with hand-computed timing and index expectations
module tb_cnn_conv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_mode = 1'b0;
  logic [2:0]  q_ksize = 3'd1;
  logic [1:0]  q_stride = 2'd1;
  logic [4:0]  q_channels = 5'd1;
  logic [11:0] q_width = 12'd4, q_height = 12'd2;
  logic [11:0] q_start_up_delay = 12'd0, q_hsync_delay = 12'd0;
  logic        q_start = 1'b0, q_abort = 1'b0;
  logic        o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run;
  logic [11:0] o_ctrl_vsync_cnt, o_ctrl_hsync_cnt, o_row, o_col;
  logic [2:0]  o_kx, o_ky;
  logic [3:0]  o_ch;
  logic        o_win_first, o_win_last, o_end_frame, o_done, o_err;
  logic [24:0] o_data_count;
  int checks = 0, passed = 0;
  int done_at, nv, nh, nd, hper, nef, ef_row, ef_col, nwin, nwf, tap_err, vmax, hmax, aborted;
  logic [31:0] cmask, rmask;

  cnn_conv_seq dut (
    .clk(clk), .rst(rst), .q_mode(q_mode), .q_ksize(q_ksize), .q_stride(q_stride),
    .q_channels(q_channels), .q_width(q_width), .q_height(q_height),
    .q_start_up_delay(q_start_up_delay), .q_hsync_delay(q_hsync_delay),
    .q_start(q_start), .q_abort(q_abort),
    .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_hsync_run(o_ctrl_hsync_run),
    .o_ctrl_data_run(o_ctrl_data_run), .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt),
    .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt), .o_row(o_row), .o_col(o_col),
    .o_kx(o_kx), .o_ky(o_ky), .o_ch(o_ch), .o_win_first(o_win_first),
    .o_win_last(o_win_last), .o_data_count(o_data_count), .o_end_frame(o_end_frame),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cfg(input logic m, input logic [2:0] k, input logic [1:0] s, input logic [4:0] c,
                     input logic [11:0] w, input logic [11:0] h, input logic [11:0] sd, input logic [11:0] hd);
    q_mode = m; q_ksize = k; q_stride = s; q_channels = c;
    q_width = w; q_height = h; q_start_up_delay = sd; q_hsync_delay = hd;
  endtask

  task automatic run(input int hold, input int abort_at);
    int c, kk, cc, i;
    kk = q_mode ? int'(q_ksize) : 1;
    cc = q_mode ? int'(q_channels) : 1;
    done_at = 0; nv = 0; nh = 0; nd = 0; hper = 0; nef = 0; ef_row = -1; ef_col = -1;
    nwin = 0; nwf = 0; tap_err = 0; vmax = 0; hmax = 0; aborted = 0; cmask = 0; rmask = 0;
    c = 0;
    @(negedge clk);
    q_start = 1'b1;
    while (c < 3000 && done_at == 0 && aborted == 0) begin
      @(negedge clk);
      c++;
      if (hold == 0 || o_ctrl_data_run) q_start = 1'b0;
      if (hold != 0 && o_ctrl_vsync_run) q_width = 12'd9;
      if (o_done) done_at = c;
      nv += int'(o_ctrl_vsync_run);
      if (o_ctrl_hsync_run && o_ctrl_hsync_cnt == 0) hper++;
      nh += int'(o_ctrl_hsync_run);
      if (int'(o_ctrl_vsync_cnt) > vmax) vmax = int'(o_ctrl_vsync_cnt);
      if (int'(o_ctrl_hsync_cnt) > hmax) hmax = int'(o_ctrl_hsync_cnt);
      if (o_end_frame) begin nef++; ef_row = int'(o_row); ef_col = int'(o_col); end
      if (o_ctrl_data_run) begin
        i = nd;
        nd++;
        if (o_win_first && o_win_last) nwf++;
        if (i < kk*kk*cc)
          if (int'(o_kx) != i % kk || int'(o_ky) != (i / kk) % kk || int'(o_ch) != i / (kk*kk) ||
              o_win_first != (i == 0) || o_win_last != (i == kk*kk*cc-1)) tap_err++;
        if (o_win_last) begin
          nwin++;
          cmask |= 32'd1 << o_col;
          rmask |= 32'd1 << o_row;
        end
        if (nd == abort_at) begin
          q_abort = 1'b1;
          @(negedge clk);
          q_abort = 1'b0;
          aborted = 1;
        end
      end
    end
    q_start = 1'b0;
    if (abort_at == 0) check("done_seen", 32'(done_at != 0), 1);
  endtask

  initial begin
    #12;
    check("rst_vsync", o_ctrl_vsync_run, 0);
    check("rst_data", o_ctrl_data_run, 0);
    check("rst_win_first", o_win_first, 0);
    check("rst_count", o_data_count, 0);
    @(negedge clk);
    rst = 1'b0;

    cfg(0, 1, 1, 1, 4, 2, 2, 1);
    run(1, 0);
    check("m0_done_at", done_at, 16);
    check("m0_vsync", nv, 3);
    check("m0_hsync", nh, 4);
    check("m0_hper", hper, 2);
    check("m0_data", nd, 8);
    check("m0_vmax", vmax, 2);
    check("m0_hmax", hmax, 1);
    check("m0_ef_n", nef, 1);
    check("m0_ef_row", ef_row, 1);
    check("m0_ef_col", ef_col, 3);
    check("m0_winflags", nwf, 8);
    check("m0_count", o_data_count, 8);
    @(negedge clk);
    check("m0_idle_after", 32'({o_ctrl_vsync_run, o_done}), 0);
    check("m0_count_hold", o_data_count, 8);

    cfg(1, 3, 1, 2, 6, 5, 1, 2);
    run(0, 0);
    check("k3_done_at", done_at, 228);
    check("k3_data", nd, 216);
    check("k3_hper", hper, 3);
    check("k3_windows", nwin, 12);
    check("k3_cols", cmask, 32'hF);
    check("k3_rows", rmask, 32'h7);
    check("k3_taps", tap_err, 0);
    check("k3_count", o_data_count, 12);
    check("k3_ef_n", nef, 1);

    cfg(1, 3, 2, 1, 7, 7, 0, 0);
    run(0, 0);
    check("s2_done_at", done_at, 86);
    check("s2_data", nd, 81);
    check("s2_cols", cmask, 32'h15);
    check("s2_rows", rmask, 32'h15);
    check("s2_count", o_data_count, 9);

    cfg(1, 1, 1, 1, 4, 2, 2, 1);
    run(0, 0);
    check("k1_done_at", done_at, 16);
    check("k1_hsync", nh, 4);
    check("k1_ef_col", ef_col, 3);
    check("k1_count", o_data_count, 8);

    cfg(1, 4, 1, 1, 3, 3, 0, 0);
    @(negedge clk);
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    check("bad_k_err", o_err, 1);
    check("bad_k_idle", 32'({o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run}), 0);
    check("bad_k_count", o_data_count, 8);
    @(negedge clk);
    check("bad_k_pulse", o_err, 0);
    cfg(1, 3, 0, 1, 6, 6, 0, 0);
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    check("bad_s_err", o_err, 1);
    check("bad_s_idle", o_ctrl_vsync_run, 0);

    cfg(0, 1, 1, 1, 4, 2, 2, 1);
    run(0, 5);
    check("ab_seen", aborted, 1);
    check("ab_idle", 32'({o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run, o_done}), 0);
    check("ab_idx", 32'({o_row, o_col, o_kx, o_ky, o_ch}), 0);
    check("ab_count", o_data_count, 4);
    repeat (3) @(negedge clk);
    check("ab_no_done", o_done, 0);
    run(0, 0);
    check("ab_re_done_at", done_at, 16);
    check("ab_re_count", o_data_count, 8);

    cfg(1, 3, 1, 2, 6, 5, 1, 2);
    @(negedge clk);
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    repeat (30) @(negedge clk);
    check("rs_running", o_ctrl_data_run, 1);
    #2 rst = 1'b1;
    #1;
    check("rs_flags", 32'({o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run, o_done, o_err}), 0);
    check("rs_idx", 32'({o_row, o_col, o_kx, o_ky, o_ch}), 0);
    check("rs_count", o_data_count, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 0);
    check("rs_re_done_at", done_at, 228);
    check("rs_re_count", o_data_count, 12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
